// File: rtl/word_transmitter.sv
// ---------------------------------------------------------------------------
// word_transmitter
//
// Sending end of the two-wire bootloader link. Accepts 32-bit words over a
// valid/ready handshake and shifts them out MSB first on dataPin. Each bit is
// qualified by a rising edge of dataOnPin. Every word is followed by an idle
// gap with both pins low.
//
// Per bit: CLK_DIV cycles of SETUP (strobe low, data driven), then CLK_DIV
// cycles of STROBE (strobe high, data held). After the last bit the block
// spends GAP_CYCLES cycles in GAP before it accepts the next word.
//
// Parameters
//   CLK_DIV     cycles per strobe half-period (>= 1)
//   GAP_CYCLES  idle cycles after each word (>= 1)
//
// Ports
//   clock       system clock, rising-edge active
//   reset       synchronous, active-low reset
//   in_valid    in_data holds a word to send
//   in_data     32-bit word to transmit
//   in_ready    block accepts a word this cycle
//   dataOnPin   bit strobe; dataPin is valid at its rising edge
//   dataPin     serial data, MSB first
//   busy        high from word acceptance through the end of the gap
//   words_sent  count of completed words, wraps 4095 -> 0
//
// Configuration
//   WORD_TX_PARITY_EN  when defined, one extra bit carrying even parity
//                      (XOR of all 32 data bits) follows bit 0, giving
//                      33 strobes per word.
// ---------------------------------------------------------------------------
module word_transmitter #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        dataOnPin,
    output logic        dataPin,
    output logic        busy,
    output logic [11:0] words_sent
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        GAP
    } state_t;

    // Divider counter holds 0 .. max(CLK_DIV, GAP_CYCLES) - 1.
    localparam int DIV_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int DIV_W   = ($clog2(DIV_MAX) < 1) ? 1 : $clog2(DIV_MAX);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(GAP_CYCLES - 1);

`ifdef WORD_TX_PARITY_EN
    localparam logic [5:0] LAST_BIT = 6'd32;
`else
    localparam logic [5:0] LAST_BIT = 6'd31;
`endif

    state_t           state;
    logic [31:0]      shift_reg;
    logic [5:0]       bit_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic             shift_fill;

`ifdef WORD_TX_PARITY_EN
    logic parity_q;

    // The parity bit is shifted in at the LSB on every shift; after the
    // 32nd shift the first copy has reached the MSB, right behind data bit 0.
    assign shift_fill = parity_q;
`else
    assign shift_fill = 1'b0;
`endif

    // NOTE: reset is sampled on the clock edge (synchronous), so it lives
    // inside the clocked block rather than in its sensitivity list.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            dataOnPin  <= 1'b0;
            dataPin    <= 1'b0;
            words_sent <= '0;
`ifdef WORD_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // below sees the register values from before this edge.
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        shift_reg <= in_data;
                        bit_cnt   <= '0;
                        div_cnt   <= '0;
                        dataPin   <= in_data[31];
                        dataOnPin <= 1'b0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
`ifdef WORD_TX_PARITY_EN
                        parity_q  <= ^in_data;
`endif
                        state     <= SETUP;
                    end
                end

                SETUP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt   <= '0;
                        dataOnPin <= 1'b1;
                        state     <= STROBE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                STROBE: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt   <= '0;
                        dataOnPin <= 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            dataPin    <= 1'b0;
                            words_sent <= words_sent + 1'b1;
                            state      <= GAP;
                        end else begin
                            // Present the next MSB on the same edge the strobe falls.
                            shift_reg <= {shift_reg[30:0], shift_fill};
                            dataPin   <= shift_reg[30];
                            bit_cnt   <= bit_cnt + 1'b1;
                            state     <= SETUP;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                GAP: begin
                    if (div_cnt == GAP_LAST) begin
                        div_cnt  <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/word_transmitter.md
Name: word_transmitter

Overview:
- Serial word sender; the transmitting end of the two-wire bootloader link (dataOnPin strobe + dataPin data) consumed by the word receiver that loads instruction memory.
- Takes 32-bit words over a valid/ready handshake and shifts them out MSB first.
- Each bit is qualified by a rising edge of dataOnPin.
- Used in test benches and host-side FPGA images to push program images into the processor's ROM.

Parameters:
- CLK_DIV, 4: clock cycles per strobe half-period, for both the setup (strobe low) and strobe-high phases. Must be >= 1.
- GAP_CYCLES, 8: idle cycles after each word, with both pins low. Must be >= 1.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  in_data holds a word to send.
- in_data  input  32  word to transmit.
- in_ready  output  1  block can accept a word this cycle.
- dataOnPin  output  1  bit strobe; dataPin is valid at its rising edge.
- dataPin  output  1  serial data, MSB first.
- busy  output  1  high from word acceptance through the end of GAP.
- words_sent  output  12  count of completed words; wraps 4095 -> 0. Matches the 12-bit memory address.

Behaviour:
- All outputs are registered. Reset (reset==0 at a clock edge) forces:
  - state IDLE;
  - in_ready=1, busy=0, dataOnPin=0, dataPin=0;
  - words_sent=0;
  - shift register, bit counter and divider counter cleared.
- Reset mid-word: transmission is abandoned immediately and the partial word is discarded. The next edge after reset deasserts starts in IDLE.
- Internal state: FSM {IDLE, SETUP, STROBE, GAP}, 32-bit shift register, 6-bit bit counter, divider counter sized for max(CLK_DIV, GAP_CYCLES).
- IDLE:
  - in_ready=1, both pins 0.
  - Acceptance: in_valid & in_ready at edge E0 loads in_data and clears the bit counter. At E0 the block enters SETUP with dataPin=in_data[31], dataOnPin=0, in_ready=0, busy=1.
- SETUP:
  - dataOnPin=0, dataPin = current MSB.
  - After CLK_DIV cycles, go to STROBE.
- STROBE:
  - dataOnPin=1; dataPin held unchanged (no change while the strobe is high).
  - After CLK_DIV cycles, if bit counter < 31: shift left by 1, increment the counter, go to SETUP with the new MSB on dataPin and dataOnPin=0 on the same edge.
  - If bit counter == 31: go to GAP.
- GAP:
  - Both pins 0.
  - words_sent increments on the edge entering GAP.
  - After GAP_CYCLES cycles, go to IDLE with in_ready=1 and busy=0.
- Timing:
  - Per word: 32 dataOnPin rising edges.
  - in_ready reasserts exactly 64*CLK_DIV + GAP_CYCLES edges after E0.
  - Back-to-back words: in_valid held high means the next word is accepted on the first IDLE cycle. Minimum word period is 64*CLK_DIV + GAP_CYCLES + 1 cycles.
- Input stability: in_valid/in_data are ignored while in_ready=0; changes to in_data after acceptance have no effect.
- in_valid without acceptance: no effect on any state.

Optional Feature:
- Macro WORD_TX_PARITY_EN.
- Defined:
  - After bit 0, one extra SETUP/STROBE bit carrying even parity (XOR of all 32 data bits) before GAP.
  - 33 strobes per word; in_ready reasserts 66*CLK_DIV + GAP_CYCLES edges after E0.
  - Bit counter terminal value is 32.
- Undefined: exactly 32 strobes; no parity logic is synthesized.

Test Plan:
- Reset defaults: CLK_DIV=2, GAP_CYCLES=4; hold reset=0 for 3 cycles -> in_ready=1, busy=0, dataOnPin=0, dataPin=0, words_sent=0.
- Single word: send 0xA5A50001 -> sampling dataPin on each dataOnPin rise gives 32 bits reconstructing 0xA5A50001; dataPin stable while the strobe is high; words_sent=1; in_ready reasserts 132 cycles after acceptance.
- Back-to-back: in_valid held high with 0xFFFFFFFF then 0x00000000 -> both words received intact; second accepted 1 cycle after in_ready returns; words_sent=2.
- Reset mid-word: reset=0 after the 10th strobe of 0x12345678, then send 0xDEADBEEF -> pins go low the next edge; words_sent=0; the next word arrives as exactly 32 clean bits equal to 0xDEADBEEF; words_sent=1.
- Counter wrap: CLK_DIV=1, GAP_CYCLES=1; send 4097 words -> words_sent reads 4095 after word 4095, 0 after word 4096, 1 after word 4097.
- With WORD_TX_PARITY_EN: send 0x00000007 -> 33 strobes, last bit 1; send 0x00000003 -> last bit 0; in_ready returns after 66*CLK_DIV + GAP_CYCLES cycles.
